// File: rtl/lc3b_pkg.sv
// Shared LC-3b decode definitions: control-store geometry, opcodes and the
// instruction-field helpers used by the decode stage and its scoreboard.
package lc3b_pkg;

   localparam int CS_WIDTH      = 23;
   localparam int CS_ADDR_WIDTH = 6;

   localparam logic [3:0] OP_BR   = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_LDB  = 4'd2;
   localparam logic [3:0] OP_STB  = 4'd3;
   localparam logic [3:0] OP_JSR  = 4'd4;
   localparam logic [3:0] OP_AND  = 4'd5;
   localparam logic [3:0] OP_LDW  = 4'd6;
   localparam logic [3:0] OP_STW  = 4'd7;
   localparam logic [3:0] OP_RTI  = 4'd8;
   localparam logic [3:0] OP_XOR  = 4'd9;
   localparam logic [3:0] OP_JMP  = 4'd12;
   localparam logic [3:0] OP_SHF  = 4'd13;
   localparam logic [3:0] OP_LEA  = 4'd14;
   localparam logic [3:0] OP_TRAP = 4'd15;

   typedef struct packed {
      logic       use_sr1;
      logic [2:0] sr1;
      logic       use_sr2;
      logic [2:0] sr2;
      logic       use_st;
      logic [2:0] st;
   } src_use_t;

   function automatic logic [CS_ADDR_WIDTH-1:0] cs_addr_of(input logic [15:0] ir);
      return {ir[15:12], ir[11], ir[5]};
   endfunction

   function automatic logic writes_reg(input logic [15:0] ir);
      case (ir[15:12])
         OP_ADD, OP_AND, OP_XOR, OP_SHF,
         OP_LDB, OP_LDW, OP_LEA, OP_JSR: return 1'b1;
         default:                        return 1'b0;
      endcase
   endfunction

   function automatic logic [2:0] drid_of(input logic [15:0] ir);
      if (ir[15:12] == OP_JSR)
         return 3'd7;
      else if (writes_reg(ir))
         return ir[11:9];
      else
         return 3'd0;
   endfunction

   function automatic src_use_t src_use(input logic [15:0] ir);
      src_use_t s;
      s     = '0;
      s.sr1 = ir[8:6];
      s.sr2 = ir[2:0];
      s.st  = ir[11:9];
      case (ir[15:12])
         OP_ADD, OP_AND, OP_XOR: begin
            s.use_sr1 = 1'b1;
            s.use_sr2 = ~ir[5];
         end
         OP_SHF, OP_LDB, OP_LDW, OP_JMP: s.use_sr1 = 1'b1;
         OP_STB, OP_STW: begin
            s.use_sr1 = 1'b1;
            s.use_st  = 1'b1;
         end
         // Only JSRR (register form) reads a base register.
         OP_JSR:  s.use_sr1 = ~ir[11];
         default: s = s;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-register scoreboard: marks in-flight destinations and reports whether
// the instruction in DE reads any of them.
import lc3b_pkg::*;

module reg_scoreboard (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_set_en,
   input  logic [2:0] i_set_id,
   input  logic       i_wb_valid,
   input  logic [2:0] i_wb_id,
   input  logic       i_rel_en,
   input  logic [2:0] i_rel_id,
   input  logic       i_query_valid,
   input  src_use_t   i_src,
   output logic       o_stall
);

   logic [7:0] r_busy;
   logic [7:0] w_busy_next;

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_bit
         logic w_set;
         logic w_clr;
         assign w_set = i_set_en & (i_set_id == 3'(gi));
         assign w_clr = (i_wb_valid & (i_wb_id == 3'(gi))) |
                        (i_rel_en & (i_rel_id == 3'(gi)));
         // Set has priority so a retiring write cannot cancel a fresh issue.
         assign w_busy_next[gi] = w_set | (r_busy[gi] & ~w_clr);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset)
         r_busy <= '0;
      else
         r_busy <= w_busy_next;
   end

   assign o_stall = i_query_valid &
                    ((i_src.use_sr1 & r_busy[i_src.sr1]) |
                     (i_src.use_sr2 & r_busy[i_src.sr2]) |
                     (i_src.use_st  & r_busy[i_src.st]));

endmodule

// File: rtl/decode_stage.sv
// LC-3b decode stage: DE latch, control-store addressing, dependency check
// and issue into the AGEX latch.
import lc3b_pkg::*;

module decode_stage (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     fe_valid,
   input  logic [15:0]              fe_ir,
   input  logic [15:0]              fe_npc,
   output logic                     fe_ready,
   output logic [CS_ADDR_WIDTH-1:0] cs_addr,
   input  logic [CS_WIDTH-1:0]      cs_bits,
   output logic                     agex_valid,
   output logic [15:0]              agex_ir,
   output logic [15:0]              agex_npc,
   output logic [CS_WIDTH-1:0]      agex_cs,
   output logic [2:0]               agex_drid,
   output logic                     agex_ld_reg,
   input  logic                     agex_ready,
   input  logic                     wb_valid,
   input  logic [2:0]               wb_drid,
   input  logic                     flush
);

   logic        r_de_valid;
   logic [15:0] r_de_ir;
   logic [15:0] r_de_npc;

   logic                r_agex_valid;
   logic [15:0]         r_agex_ir;
   logic [15:0]         r_agex_npc;
   logic [CS_WIDTH-1:0] r_agex_cs;
   logic [2:0]          r_agex_drid;
   logic                r_agex_ld_reg;

   logic w_dep_stall;
   logic w_agex_free;
   logic w_de_advance;
   logic w_load_de;
   logic w_de_ld_reg;
   logic [2:0] w_de_drid;

   assign w_agex_free  = ~r_agex_valid | agex_ready;
   assign w_de_advance = r_de_valid & ~w_dep_stall & w_agex_free & ~flush;
   assign fe_ready     = (~r_de_valid | w_de_advance) & ~flush;
   assign w_load_de    = fe_valid & fe_ready;
   assign w_de_ld_reg  = writes_reg(r_de_ir);
   assign w_de_drid    = drid_of(r_de_ir);

   // While DE is held the ROM re-reads its instruction so cs_bits stays aligned.
   assign cs_addr = fe_ready ? cs_addr_of(fe_ir) : cs_addr_of(r_de_ir);

   reg_scoreboard u_sb (
      .clk           (clk),
      .reset         (reset),
      .i_set_en      (w_de_advance & w_de_ld_reg),
      .i_set_id      (w_de_drid),
      .i_wb_valid    (wb_valid),
      .i_wb_id       (wb_drid),
      .i_rel_en      (flush & r_agex_valid & r_agex_ld_reg),
      .i_rel_id      (r_agex_drid),
      .i_query_valid (r_de_valid),
      .i_src         (src_use(r_de_ir)),
      .o_stall       (w_dep_stall)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_de_valid <= 1'b0;
         r_de_ir    <= '0;
         r_de_npc   <= '0;
      end else if (flush) begin
         r_de_valid <= 1'b0;
      end else if (w_load_de) begin
         r_de_valid <= 1'b1;
         r_de_ir    <= fe_ir;
         r_de_npc   <= fe_npc;
      end else if (w_de_advance) begin
         r_de_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_agex_valid  <= 1'b0;
         r_agex_ir     <= '0;
         r_agex_npc    <= '0;
         r_agex_cs     <= '0;
         r_agex_drid   <= '0;
         r_agex_ld_reg <= 1'b0;
      end else if (flush) begin
         r_agex_valid <= 1'b0;
      end else if (w_de_advance) begin
         r_agex_valid  <= 1'b1;
         r_agex_ir     <= r_de_ir;
         r_agex_npc    <= r_de_npc;
         r_agex_cs     <= cs_bits;
         r_agex_drid   <= w_de_drid;
         r_agex_ld_reg <= w_de_ld_reg;
      end else if (agex_ready) begin
         r_agex_valid <= 1'b0;
      end
   end

   assign agex_valid  = r_agex_valid;
   assign agex_ir     = r_agex_ir;
   assign agex_npc    = r_agex_npc;
   assign agex_cs     = r_agex_cs;
   assign agex_drid   = r_agex_drid;
   assign agex_ld_reg = r_agex_ld_reg;

endmodule
